// File: rtl/trdb_pkg.sv
// Shared trace debugger types and constants: stream geometry, header layout and deframer state.
package trdb_pkg;

    localparam int unsigned TRDB_HDR_LEN_W      = 7;
    localparam int unsigned TRDB_HDR_FILLER_BIT = 7;
    localparam int unsigned TRDB_STREAM_W       = 32;
    localparam int unsigned TRDB_BYTE_W         = 8;
    localparam int unsigned TRDB_BYTE_IDX_W     = 2;

    // Header byte: filler flag in the MSB, payload length below it
    typedef struct packed {
        logic                      filler;
        logic [TRDB_HDR_LEN_W-1:0] len;
    } trdb_hdr_t;

    typedef enum logic [1:0] {
        DF_HDR,
        DF_PAY,
        DF_SKIP,
        DF_OUT
    } trdb_deframer_state_e;

endpackage

// File: rtl/trdb_word_byte_buf.sv
// Single-word holding register that hands the stream out one byte at a time, byte 0 first.
module trdb_word_byte_buf
    import trdb_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [TRDB_STREAM_W-1:0] word_i,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    output logic [TRDB_BYTE_W-1:0]   byte_o,
    output logic                     byte_valid_o,
    input  logic                     byte_pop_i
);

    logic [TRDB_STREAM_W-1:0]   word_q;
    logic [TRDB_BYTE_IDX_W-1:0] idx_q;
    logic                       vld_q;
    logic                       pop_c;
    logic                       last_pop_c;
    logic                       load_c;

    assign pop_c        = byte_pop_i & vld_q;
    assign last_pop_c   = pop_c & (idx_q == TRDB_BYTE_IDX_W'(3));
    // A new word may land in the same cycle the last byte of the old one leaves
    assign word_ready_o = ~flush_i & (~vld_q | last_pop_c);
    assign load_c       = word_valid_i & word_ready_o;

    assign byte_o       = word_q[{idx_q, 3'b000} +: TRDB_BYTE_W];
    assign byte_valid_o = vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
        end else if (flush_i) begin
            idx_q <= '0;
            vld_q <= 1'b0;
        end else if (load_c) begin
            word_q <= word_i;
            idx_q  <= '0;
            vld_q  <= 1'b1;
        end else if (pop_c) begin
            if (last_pop_c) begin
                vld_q <= 1'b0;
            end
            idx_q <= TRDB_BYTE_IDX_W'(idx_q + TRDB_BYTE_IDX_W'(1));
        end
    end

endmodule

// File: rtl/trdb_packet_deframer.sv
// Recovers length-prefixed trace packets from the 32-bit trace stream, one packet at a time.
// Optional statistics counters are built when TRDB_DEFRAMER_STATS_EN is defined.
module trdb_packet_deframer
    import trdb_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 16,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [TRDB_STREAM_W-1:0]       word_i,
    input  logic                           word_valid_i,
    output logic                           word_ready_o,
    output logic [MAX_PAYLOAD_BYTES*8-1:0] pkt_payload_o,
    output logic [TRDB_HDR_LEN_W-1:0]      pkt_len_o,
    output logic                           pkt_valid_o,
    input  logic                           pkt_ready_i,
    output logic                           err_o,
    output logic [CNT_W-1:0]               pkt_cnt_o,
    output logic [CNT_W-1:0]               err_cnt_o
);

    localparam int unsigned PAY_W = MAX_PAYLOAD_BYTES * TRDB_BYTE_W;

    trdb_deframer_state_e      state_q, state_n;
    logic [TRDB_HDR_LEN_W-1:0] rem_q, rem_n;
    logic [TRDB_HDR_LEN_W-1:0] len_q, len_n;
    logic [PAY_W-1:0]          payload_q, payload_n;
    logic                      err_q, err_n;

    logic [TRDB_BYTE_W-1:0]    byte_c;
    logic                      byte_valid_c;
    logic                      pop_c;
    trdb_hdr_t                 hdr_c;
    logic [TRDB_HDR_LEN_W-1:0] slot_c;

    trdb_word_byte_buf u_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .word_i      (word_i),
        .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o),
        .byte_o      (byte_c),
        .byte_valid_o(byte_valid_c),
        .byte_pop_i  (pop_c)
    );

    assign pop_c  = byte_valid_c & (state_q != DF_OUT) & ~flush_i;
    assign hdr_c  = trdb_hdr_t'(byte_c);
    assign slot_c = TRDB_HDR_LEN_W'(len_q - rem_q);

    // Next-state and payload assembly
    always_comb begin
        state_n   = state_q;
        rem_n     = rem_q;
        len_n     = len_q;
        payload_n = payload_q;
        err_n     = 1'b0;
        if (flush_i) begin
            state_n = DF_HDR;
            rem_n   = '0;
        end else begin
            unique case (state_q)
                DF_HDR: begin
                    if (byte_valid_c && !hdr_c.filler) begin
                        rem_n = hdr_c.len;
                        if (hdr_c.len > TRDB_HDR_LEN_W'(MAX_PAYLOAD_BYTES)) begin
                            err_n   = 1'b1;
                            state_n = DF_SKIP;
                        end else begin
                            len_n     = hdr_c.len;
                            payload_n = '0;
                            state_n   = (hdr_c.len == '0) ? DF_OUT : DF_PAY;
                        end
                    end
                end
                DF_PAY: begin
                    if (byte_valid_c) begin
                        for (int unsigned k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
                            if (slot_c == TRDB_HDR_LEN_W'(k)) begin
                                payload_n[k*TRDB_BYTE_W +: TRDB_BYTE_W] = byte_c;
                            end
                        end
                        rem_n = TRDB_HDR_LEN_W'(rem_q - TRDB_HDR_LEN_W'(1));
                        if (rem_q == TRDB_HDR_LEN_W'(1)) begin
                            state_n = DF_OUT;
                        end
                    end
                end
                DF_SKIP: begin
                    if (byte_valid_c) begin
                        rem_n = TRDB_HDR_LEN_W'(rem_q - TRDB_HDR_LEN_W'(1));
                        if (rem_q == TRDB_HDR_LEN_W'(1)) begin
                            state_n = DF_HDR;
                        end
                    end
                end
                DF_OUT: begin
                    if (pkt_ready_i) begin
                        state_n = DF_HDR;
                    end
                end
                default: state_n = DF_HDR;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= DF_HDR;
            rem_q     <= '0;
            len_q     <= '0;
            payload_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            rem_q     <= rem_n;
            len_q     <= len_n;
            payload_q <= payload_n;
            err_q     <= err_n;
        end
    end

    assign pkt_valid_o   = (state_q == DF_OUT);
    assign pkt_len_o     = len_q;
    assign pkt_payload_o = payload_q;
    assign err_o         = err_q;

`ifdef TRDB_DEFRAMER_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Saturating counters; survive flush, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (pkt_valid_o && pkt_ready_i && !(&pkt_cnt_q)) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
            if (err_n && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;
`else
    assign pkt_cnt_o = '0;
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trdb_packet_deframer.sv
// Bench for trdb_packet_deframer: directed word streams checked against a packet-level reference parser.
module tb_trdb_packet_deframer;

    localparam int unsigned MAXB = 16;
    localparam int unsigned PW   = MAXB * 8;
    localparam int unsigned CW   = 16;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic [31:0]   word_i;
    logic          word_valid_i;
    logic          word_ready_o;
    logic [PW-1:0] pkt_payload_o;
    logic [6:0]    pkt_len_o;
    logic          pkt_valid_o;
    logic          pkt_ready_i;
    logic          err_o;
    logic [CW-1:0] pkt_cnt_o;
    logic [CW-1:0] err_cnt_o;

    trdb_packet_deframer #(.MAX_PAYLOAD_BYTES(MAXB), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .pkt_payload_o(pkt_payload_o),
        .pkt_len_o    (pkt_len_o),
        .pkt_valid_o  (pkt_valid_o),
        .pkt_ready_i  (pkt_ready_i),
        .err_o        (err_o),
        .pkt_cnt_o    (pkt_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            len;
        logic [PW-1:0] payload;
    } pkt_t;

    pkt_t       exp_q[$];
    pkt_t       got_q[$];
    logic [7:0] pend_q[$];
    int         exp_err  = 0;
    int         err_seen = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         prev_err = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference parser: emits a packet only once the whole header+payload is present
    function automatic void model_parse();
        while (pend_q.size() > 0) begin
            logic [7:0] h;
            int         l;
            pkt_t       p;
            h = pend_q[0];
            if (h[7]) begin
                void'(pend_q.pop_front());
                continue;
            end
            l = int'(h[6:0]);
            if (pend_q.size() < l + 1) break;
            void'(pend_q.pop_front());
            if (l > int'(MAXB)) begin
                exp_err++;
                for (int i = 0; i < l; i++) void'(pend_q.pop_front());
            end else begin
                p.len     = l;
                p.payload = '0;
                for (int i = 0; i < l; i++) p.payload[8*i +: 8] = pend_q.pop_front();
                exp_q.push_back(p);
            end
        end
    endfunction

    function automatic void model_push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) pend_q.push_back(w[8*i +: 8]);
        model_parse();
    endfunction

    function automatic void model_flush();
        pend_q.delete();
    endfunction

    // Per-cycle compare against the model, sampled mid low phase
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_ni) begin
                if (err_o) begin
                    err_seen++;
                    n_checks++;
                    if (prev_err) begin
                        n_fail++;
                        $display("FAIL err_o_pulse: got two-cycle err_o expected one-cycle pulse");
                    end
                end
                prev_err = err_o;
                if (pkt_valid_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pkt: got len %0d payload %h expected no packet",
                                 pkt_len_o, pkt_payload_o);
                    end else begin
                        check("pkt_len", PW'(pkt_len_o), PW'(exp_q[0].len));
                        check("pkt_payload", pkt_payload_o, exp_q[0].payload);
                        if (pkt_ready_i) begin
                            pkt_t p;
                            p.len     = int'(pkt_len_o);
                            p.payload = pkt_payload_o;
                            got_q.push_back(p);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end else begin
                prev_err = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        word_i       = w;
        word_valid_i = 1'b1;
        model_push_word(w);
        #1;
        while (!word_ready_o && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!word_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL word_accept_timeout: got ready 0 expected word %h accepted", w);
        end
        @(negedge clk);
        word_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pkt_valid_o) && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({name, "_drained"}, PW'(exp_q.size()), PW'(0));
        check({name, "_err_count"}, PW'(err_seen), PW'(exp_err));
    endtask

    task automatic check_got(input string name, input int idx, input int len, input logic [PW-1:0] pay);
        if (idx >= got_q.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0d packets expected index %0d present", name, got_q.size(), idx);
        end else begin
            check({name, "_len"}, PW'(got_q[idx].len), PW'(len));
            check({name, "_pay"}, got_q[idx].payload, pay);
        end
    endtask

    initial begin
        int        base;
        int        err0;
        logic [7:0] b[24];
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        word_i       = '0;
        word_valid_i = 1'b0;
        pkt_ready_i  = 1'b1;
        #1;
        check("rst_valid", PW'(pkt_valid_o), PW'(0));
        check("rst_ready", PW'(word_ready_o), PW'(1));
        check("rst_err", PW'(err_o), PW'(0));
        check("rst_len", PW'(pkt_len_o), PW'(0));
        check("rst_payload", pkt_payload_o, PW'(0));
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // 1: filler then a 2-byte packet, with exact latency
        base = got_q.size();
        word_i       = 32'hBBAA0280;
        word_valid_i = 1'b1;
        model_push_word(32'hBBAA0280);
        check("model_t1_len", PW'(exp_q[0].len), PW'(2));
        check("model_t1_pay", exp_q[0].payload, PW'(32'hBBAA));
        #1;
        check("t1_ready", PW'(word_ready_o), PW'(1));
        @(negedge clk);
        word_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("t1_valid_early", PW'(pkt_valid_o), PW'(0));
        end
        @(negedge clk);
        #1;
        check("t1_valid_latency", PW'(pkt_valid_o), PW'(1));
        wait_drain("t1");
        check_got("t1", base, 2, PW'(32'hBBAA));

        // 2: header in byte 3 spans a word, then a zero-length packet
        @(negedge clk);
        base = got_q.size();
        send_word(32'h03808080);
        send_word(32'h00332211);
        wait_drain("t2");
        check_got("t2_a", base, 3, PW'(32'h332211));
        check_got("t2_b", base + 1, 0, PW'(0));

        // 3: oversize packet skipped with an error pulse, then a 1-byte packet
        @(negedge clk);
        base = got_q.size();
        err0 = exp_err;
        b[0] = 8'h14;
        for (int i = 1; i <= 20; i++) b[i] = 8'(8'h40 + i);
        b[21] = 8'h01;
        b[22] = 8'h5A;
        b[23] = 8'h80;
        for (int wd = 0; wd < 6; wd++) send_word({b[4*wd+3], b[4*wd+2], b[4*wd+1], b[4*wd]});
        check("model_t3_err", PW'(exp_err - err0), PW'(1));
        wait_drain("t3");
        check("t3_err_pulses", PW'(err_seen - err0), PW'(1));
        check_got("t3", base, 1, PW'(8'h5A));
        check("t3_pkt_count", PW'(got_q.size() - base), PW'(1));
`ifdef TRDB_DEFRAMER_STATS_EN
        check("t3_err_cnt", PW'(err_cnt_o), PW'(1));
        check("t3_pkt_cnt", PW'(pkt_cnt_o), PW'(4));
`endif

        // 4: consumer back-pressure with words queued behind the held packet
        @(negedge clk);
        base = got_q.size();
        pkt_ready_i = 1'b0;
        fork
            begin
                send_word(32'h44332203);
                send_word(32'h00BBAA02);
                send_word(32'h80808001);
            end
            begin
                int n;
                n = 0;
                while (!pkt_valid_o && n < 100) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                check("t4_valid_seen", PW'(pkt_valid_o), PW'(1));
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    check("t4_hold_valid", PW'(pkt_valid_o), PW'(1));
                    check("t4_hold_len", PW'(pkt_len_o), PW'(3));
                    check("t4_hold_pay", pkt_payload_o, PW'(32'h443322));
                    check("t4_hold_ready", PW'(word_ready_o), PW'(0));
                end
                @(negedge clk);
                pkt_ready_i = 1'b1;
            end
        join
        wait_drain("t4");
        check_got("t4_a", base, 3, PW'(32'h443322));
        check_got("t4_b", base + 1, 2, PW'(32'hBBAA));
        check_got("t4_c", base + 2, 0, PW'(0));
        check_got("t4_d", base + 3, 1, PW'(8'h80));

        // 5: flush mid-payload drops the partial packet and refuses a same-cycle word
        @(negedge clk);
        base = got_q.size();
        send_word(32'hCCBBAA04);
        @(negedge clk);
        @(negedge clk);
        flush_i      = 1'b1;
        word_i       = 32'h00007701;
        word_valid_i = 1'b1;
        model_flush();
        #1;
        check("t5_flush_ready", PW'(word_ready_o), PW'(0));
        @(negedge clk);
        flush_i      = 1'b0;
        word_valid_i = 1'b0;
        #1;
        check("t5_flush_valid", PW'(pkt_valid_o), PW'(0));
        send_word(32'h00007701);
        wait_drain("t5");
        check_got("t5_a", base, 1, PW'(8'h77));
        check_got("t5_b", base + 1, 0, PW'(0));
        check("t5_pkt_count", PW'(got_q.size() - base), PW'(3));

        // 6: asynchronous reset in the middle of a payload
        @(negedge clk);
`ifdef TRDB_DEFRAMER_STATS_EN
        check("t6_pkt_cnt_pre", PW'(pkt_cnt_o), PW'(11));
        check("t6_err_cnt_pre", PW'(err_cnt_o), PW'(1));
`endif
        send_word(32'h33221104);
        @(negedge clk);
        #3;
        rst_ni = 1'b0;
        model_flush();
        #1;
        check("t6_rst_valid", PW'(pkt_valid_o), PW'(0));
        check("t6_rst_ready", PW'(word_ready_o), PW'(1));
        check("t6_rst_pkt_cnt", PW'(pkt_cnt_o), PW'(0));
        check("t6_rst_err_cnt", PW'(err_cnt_o), PW'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        base = got_q.size();
        send_word(32'h00007701);
        wait_drain("t6");
        check_got("t6", base, 1, PW'(8'h77));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
